alu8_sched: RTL and testbench

Round-robin scheduler that shares one `alu8` instance among `NREQ` independent requesters. Each requester issues an operation (`a`, `b`, `opcode`) over a valid/ready handshake. The scheduler grants one requester at a time, registers its operands into the shared `alu8`, and returns a registered result tagged with the requester ID over a valid/ready response channel. It sits between the client blocks and the combinational 8-bit ALU datapath.

---
 rtl/alu8_pkg.sv | 22 ++
 rtl/alu8.sv | 31 +++
 rtl/alu8_rr_arb.sv | 45 ++++
 rtl/alu8_sched.sv | 150 +++++++++++++++
 tb/tb_alu8_sched.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu8_pkg.sv
// alu8_pkg
// Shared definitions for the alu8 scheduler slice: the 3-bit opcode
// constants understood by alu8 and the scheduler FSM state type.
// No ports; imported by alu8, alu8_rr_arb and alu8_sched.
package alu8_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

endpackage

// File: rtl/alu8.sv
// alu8
// Purely combinational 8-bit ALU shared by all requesters of alu8_sched.
// Ports:
//   a, b : 8-bit operands
//   op   : 3-bit opcode (OP_* from alu8_pkg)
//   y    : 8-bit result, modulo 256, no flags
module alu8
    import alu8_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    output logic [7:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_SHL: y = {a[6:0], 1'b0};
            OP_SHR: y = {1'b0, a[7:1]};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu8_rr_arb.sv
// alu8_rr_arb
// Combinational round-robin arbiter. The requester just after ptr has the
// highest priority, and the search wraps modulo NREQ.
// Ports:
//   req     : per-requester request bits
//   ptr     : index of the most recently granted requester
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : binary index of the granted requester (0 when no request)
module alu8_rr_arb
    import alu8_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic found;

    // Two ascending passes stand in for a rotated search: first the indices
    // above ptr, then the wrapped-around indices up to and including ptr.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (IDW'(i) > ptr)) begin
                found   = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (IDW'(i) <= ptr)) begin
                found   = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/alu8_sched.sv
// alu8_sched
// Shares one alu8 among NREQ requesters. One operation at a time is
// accepted (IDLE), executed from registered operands (EXEC), and its result
// is held on the response channel until the consumer takes it (RESP).
// Ports:
//   clk, rst_n          : clock and synchronous active-low reset
//   req_valid/req_ready : per-requester handshake, at most one ready bit high
//   req_a, req_b        : packed 8-bit operands, requester i at [8i+7:8i]
//   req_op              : packed 3-bit opcodes, requester i at [3i+2:3i]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id, rsp_out     : owning requester index and 8-bit result
//   busy                : high whenever the FSM is not in IDLE
module alu8_sched
    import alu8_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_out,
    output logic              busy
);

    sched_state_t    state;
    sched_state_t    state_nxt;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  id_q;
    logic [IDW-1:0]  gnt_idx;
    logic [NREQ-1:0] gnt;
    logic [7:0]      a_q;
    logic [7:0]      b_q;
    logic [2:0]      op_q;
    logic [7:0]      sel_a;
    logic [7:0]      sel_b;
    logic [2:0]      sel_op;
    logic [7:0]      alu_y;
    logic            accept;
    logic            capture;
    logic            rsp_done;

    alu8_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    alu8 u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

    // The grant is one-hot, so an OR-style mux over requesters picks the
    // winner's operands without a variable-width index.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_a  = req_a[8*i +: 8];
                sel_b  = req_b[8*i +: 8];
                sel_op = req_op[3*i +: 3];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // req_ready is also held low while reset is asserted, so nothing appears
    // to be accepted in a cycle that the reset is about to discard.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        capture   = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && (|req_valid)) begin
                    req_ready = gnt;
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                capture   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= IDW'(NREQ - 1);
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_out   <= '0;
            rsp_id    <= '0;
        end else begin
            if (accept) begin
                a_q  <= sel_a;
                b_q  <= sel_b;
                op_q <= sel_op;
                id_q <= gnt_idx;
                ptr  <= gnt_idx;
            end
            if (capture) begin
                rsp_out   <= alu_y;
                rsp_id    <= id_q;
                rsp_valid <= 1'b1;
            end else if (rsp_done) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu8_sched.sv
// tb_alu8_sched
// Self-checking bench for alu8_sched (NREQ=4). A transaction-level model
// tracks per-requester operation queues, the round-robin pointer and the
// single in-flight operation; results come from plain integer arithmetic.
module tb_alu8_sched;
    import alu8_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } op_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic [NREQ*3-1:0] req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [7:0]        rsp_out;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    op_t  opMem[NREQ][64];
    int   head[NREQ];
    int   tail[NREQ];
    int   modelPtr;
    bit   inflight;
    int   inflightAge;
    int   inflightId;
    op_t  inflightOp;
    bit   rspSeen;
    int   cyc = 0;

    int         grantLog[$];
    int         logId[$];
    logic [7:0] logOut[$];
    int         logAccCyc[$];
    int         logRspCyc[$];
    int         logHsCyc[$];

    always #5 clk = ~clk;

    alu8_sched #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_out   (rsp_out),
        .busy      (busy)
    );

    function automatic logic [7:0] refAlu(input op_t o);
        int r;
        int x;
        int y;
        x = int'(o.a);
        y = int'(o.b);
        case (int'(o.op))
            0: r = x + y;
            1: r = x - y;
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = 255 - x;
            6: r = x * 2;
            default: r = x / 2;
        endcase
        r = ((r % 256) + 256) % 256;
        return 8'(r);
    endfunction

    function automatic int pickRR(input logic [NREQ-1:0] v, input int p);
        logic [NREQ-1:0] t;
        for (int k = 1; k <= NREQ; k++) begin
            t = v >> ((p + k) % NREQ);
            if (t[0]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int oneHotIdx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    function automatic bit allEmpty();
        for (int i = 0; i < NREQ; i++) begin
            if (head[i] != tail[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ*8-1:0] a,
                                 input logic [NREQ*8-1:0] b, input logic [NREQ*3-1:0] o,
                                 input logic rr);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        req_op    = o;
        rsp_ready = rr;
    endtask

    task automatic queueOp(input int id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        if (head[id] == tail[id]) begin
            head[id] = 0;
            tail[id] = 0;
        end
        opMem[id][tail[id]] = {a, b, op};
        tail[id]++;
    endtask

    task automatic clearLogs();
        grantLog.delete();
        logId.delete();
        logOut.delete();
        logAccCyc.delete();
        logRspCyc.delete();
        logHsCyc.delete();
    endtask

    task automatic resetModel();
        modelPtr = NREQ - 1;
        inflight = 1'b0;
        inflightAge = 0;
        rspSeen = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    endtask

    // Holds reset for two cycles with every requester asserting valid, checks
    // the reset output values, then releases reset with idle inputs.
    task automatic resetDut();
        rst_n = 1'b0;
        applyStimulus('1, '1, '1, '1, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_out", 32'(rsp_out), 32'd0);
        checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        applyStimulus('0, '0, '0, '0, 1'b1);
        resetModel();
    endtask

    // Cycle-by-cycle driver and checker. Requesters with queued operations
    // assert valid; the model predicts grants, response timing and values.
    task automatic runEngine(input int readyPct, input int stallLen, input int budget);
        logic [NREQ-1:0]   v;
        logic [NREQ*8-1:0] aBus;
        logic [NREQ*8-1:0] bBus;
        logic [NREQ*3-1:0] oBus;
        logic [NREQ-1:0]   expReady;
        logic              rr;
        int  stall;
        int  accId;
        int  c;
        int  pick;
        bit  acc;
        bit  hs;
        bit  done;
        bit  expValid;
        stall = stallLen;
        acc   = 1'b0;
        hs    = 1'b0;
        done  = 1'b0;
        c     = 0;
        accId = 0;
        while (!done && c < budget) begin
            @(negedge clk);
            c++;
            cyc++;
            if (hs) inflight = 1'b0;
            if (inflight) inflightAge++;
            if (acc) begin
                inflight    = 1'b1;
                inflightAge = 1;
                inflightId  = accId;
                inflightOp  = opMem[accId][head[accId]];
                head[accId]++;
                modelPtr    = accId;
                rspSeen     = 1'b0;
            end
            v    = '0;
            aBus = '0;
            bBus = '0;
            oBus = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (head[i] < tail[i]) begin
                    v[i] = 1'b1;
                    aBus[8*i +: 8] = opMem[i][head[i]].a;
                    bBus[8*i +: 8] = opMem[i][head[i]].b;
                    oBus[3*i +: 3] = opMem[i][head[i]].op;
                end
            end
            expValid = inflight && (inflightAge >= 2);
            if (expValid && stall > 0) begin
                rr = 1'b0;
                stall--;
            end else begin
                rr = ($urandom_range(99) < readyPct);
            end
            applyStimulus(v, aBus, bBus, oBus, rr);
            #1;
            pick = pickRR(v, modelPtr);
            expReady = '0;
            if (!inflight && pick >= 0) expReady = NREQ'(1) << pick;
            checkOutput("req_ready", 32'(req_ready), 32'(expReady));
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(expValid));
            checkOutput("busy", 32'(busy), 32'(inflight));
            if (expValid) begin
                checkOutput("rsp_out", 32'(rsp_out), 32'(refAlu(inflightOp)));
                checkOutput("rsp_id", 32'(rsp_id), inflightId);
            end
            if (rsp_valid === 1'b1 && !rspSeen) begin
                logRspCyc.push_back(cyc);
                rspSeen = 1'b1;
            end
            acc   = !inflight && (pick >= 0);
            accId = pick;
            if (acc) begin
                grantLog.push_back(oneHotIdx(req_ready));
                logAccCyc.push_back(cyc);
            end
            hs = expValid && rr;
            if (hs) begin
                logOut.push_back(rsp_out);
                logId.push_back(int'(rsp_id));
                logHsCyc.push_back(cyc);
            end
            done = !acc && (!inflight || hs) && allEmpty();
        end
        if (!done) begin
            checks++;
            failures++;
            $error("[TB] FAIL engine_timeout: observed %0d cycles without drain, expected drain within budget", budget);
        end
        inflight = 1'b0;
    endtask

    initial begin
        int         expOrder[6];
        logic [7:0] expOps[8];
        expOrder = '{0, 1, 2, 3, 0, 1};
        expOps   = '{8'hFF, 8'h55, 8'h00, 8'hFF, 8'hFF, 8'h55, 8'h54, 8'h55};

        $display("[TB] reset");
        resetDut();

        $display("[TB] single request");
        clearLogs();
        queueOp(0, 8'd3, 8'd5, OP_ADD);
        runEngine(100, 0, 50);
        checkOutput("single_count", logOut.size(), 1);
        checkOutput("single_grant", grantLog[0], 0);
        checkOutput("single_out", 32'(logOut[0]), 32'd8);
        checkOutput("single_id", logId[0], 0);
        checkOutput("single_latency", logRspCyc[0] - logAccCyc[0], 2);
        @(negedge clk);
        #1;
        checkOutput("single_busy_fall", 32'(busy), 32'd0);
        checkOutput("single_rsp_valid_fall", 32'(rsp_valid), 32'd0);

        $display("[TB] wrap-around");
        clearLogs();
        queueOp(2, 8'd255, 8'd1, OP_ADD);
        queueOp(2, 8'd0, 8'd1, OP_SUB);
        runEngine(100, 0, 50);
        checkOutput("wrap_count", logOut.size(), 2);
        checkOutput("wrap_add_out", 32'(logOut[0]), 32'd0);
        checkOutput("wrap_sub_out", 32'(logOut[1]), 32'd255);
        checkOutput("wrap_add_id", logId[0], 2);
        checkOutput("wrap_sub_id", logId[1], 2);

        $display("[TB] fairness");
        resetDut();
        clearLogs();
        for (int i = 0; i < NREQ; i++) begin
            queueOp(i, 8'($urandom), 8'($urandom), 3'($urandom));
            queueOp(i, 8'($urandom), 8'($urandom), 3'($urandom));
        end
        runEngine(100, 0, 100);
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("fair_grant%0d", k), grantLog[k], expOrder[k]);
            checkOutput($sformatf("fair_id%0d", k), logId[k], expOrder[k]);
        end

        $display("[TB] backpressure");
        clearLogs();
        queueOp(0, 8'h12, 8'h34, OP_ADD);
        queueOp(1, 8'h40, 8'h03, OP_SUB);
        runEngine(100, 6, 100);
        checkOutput("bp_grant0", grantLog[0], 0);
        checkOutput("bp_grant1", grantLog[1], 1);
        checkOutput("bp_out0", 32'(logOut[0]), 32'h46);
        checkOutput("bp_hold", logHsCyc[0] - logRspCyc[0], 6);
        checkOutput("bp_next_accept", logAccCyc[1], logHsCyc[0] + 1);
        checkOutput("bp_out1", 32'(logOut[1]), 32'h3D);
        checkOutput("bp_id1", logId[1], 1);

        $display("[TB] all opcodes");
        clearLogs();
        for (int k = 0; k < 8; k++) queueOp(2, 8'hAA, 8'h55, 3'(k));
        runEngine(70, 0, 200);
        checkOutput("ops_count", logOut.size(), 8);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("ops_out%0d", k), 32'(logOut[k]), 32'(expOps[k]));
        end

        $display("[TB] mid-operation reset");
        clearLogs();
        @(negedge clk);
        applyStimulus(4'b1000, {8'hAA, 24'h0}, {8'h55, 24'h0}, {OP_XOR, 9'h0}, 1'b1);
        #1;
        checkOutput("mr_grant", 32'(req_ready), 32'h8);
        @(negedge clk);
        applyStimulus('0, '0, '0, '0, 1'b1);
        #1;
        checkOutput("mr_busy_exec", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mr_rsp_out", 32'(rsp_out), 32'd0);
        checkOutput("mr_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("mr_busy", 32'(busy), 32'd0);
        checkOutput("mr_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            checkOutput("mr_no_rsp", 32'(rsp_valid), 32'd0);
        end
        resetModel();
        queueOp(3, 8'h0F, 8'hF0, OP_OR);
        queueOp(0, 8'h80, 8'h80, OP_ADD);
        runEngine(100, 0, 100);
        checkOutput("mr_first_grant", grantLog[0], 0);
        checkOutput("mr_second_grant", grantLog[1], 3);
        checkOutput("mr_out0", 32'(logOut[0]), 32'h00);
        checkOutput("mr_out1", 32'(logOut[1]), 32'hFF);

        $display("[TB] random traffic");
        clearLogs();
        for (int k = 0; k < 40; k++) begin
            queueOp(int'($urandom_range(NREQ - 1)), 8'($urandom), 8'($urandom), 3'($urandom));
        end
        runEngine(50, 0, 3000);
        checkOutput("rand_count", logOut.size(), 40);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
